// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: pipeline-stage info in,
// stall/flush/forward controls out.
interface hazard_unit_if #(
  parameter int M = 4
);
  logic [M-1:0] regAD;
  logic [M-1:0] regBD;
  logic [M-1:0] regAE;
  logic [M-1:0] regBE;
  logic [M-1:0] regScr_E;
  logic         regw_E;
  logic         regmem_E;
  logic         branch_E;
  logic         taken_E;
  logic [4:0]   op_code_E;
  logic [M-1:0] regScr_M;
  logic         regw_M;
  logic [M-1:0] regScr_W;
  logic         regw_W;
  logic         stall_F;
  logic         stall_D;
  logic         stall_E;
  logic         flush_D;
  logic         flush_E;
  logic [1:0]   fwdA_E;
  logic [1:0]   fwdB_E;

  modport master (
    output regAD, regBD, regAE, regBE,
    output regScr_E, regw_E, regmem_E,
    output branch_E, taken_E, op_code_E,
    output regScr_M, regw_M,
    output regScr_W, regw_W,
    input  stall_F, stall_D, stall_E,
    input  flush_D, flush_E,
    input  fwdA_E, fwdB_E
  );

  modport slave (
    input  regAD, regBD, regAE, regBE,
    input  regScr_E, regw_E, regmem_E,
    input  branch_E, taken_E, op_code_E,
    input  regScr_M, regw_M,
    input  regScr_W, regw_W,
    output stall_F, stall_D, stall_E,
    output flush_D, flush_E,
    output fwdA_E, fwdB_E
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall,
// taken-branch flush and multi-cycle execute occupancy.
module hazard_unit #(
  parameter int         M      = 4,
  parameter logic [4:0] MC_OP  = 5'b11111,
  parameter int         MC_LAT = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE,
    MC_BUSY,
    MC_LAST,
    BR_RECOVER
  } state_t;

  localparam bit         LONG_MC  = (MC_LAT > 2);
  localparam logic [3:0] CNT_INIT =
    LONG_MC ? 4'(MC_LAT - 3) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic taken;
  logic mc_hit;
  logic lu_hit;

  assign taken  = hz.branch_E & hz.taken_E;
  assign mc_hit = (hz.op_code_E == MC_OP);
  assign lu_hit = hz.regmem_E & hz.regw_E &
                  ((hz.regScr_E == hz.regAD) |
                   (hz.regScr_E == hz.regBD));

  // State and occupancy counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: taken branch beats MC_OP entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (taken) begin
          state_d = BR_RECOVER;
        end else if (mc_hit) begin
          if (LONG_MC) begin
            state_d = MC_BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = MC_LAST;
          end
        end
      end
      MC_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = MC_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MC_LAST: begin
        state_d = taken ? BR_RECOVER : IDLE;
      end
      BR_RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall/flush decode; MC_LAST ignores MC_OP
  always_comb begin
    hz.stall_F = 1'b0;
    hz.stall_D = 1'b0;
    hz.stall_E = 1'b0;
    hz.flush_D = 1'b0;
    hz.flush_E = 1'b0;
    if (rst) begin
      hz.flush_D = 1'b1;
      hz.flush_E = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, MC_LAST: begin
          if (taken) begin
            hz.flush_D = 1'b1;
            hz.flush_E = 1'b1;
          end else if (state_q == IDLE && mc_hit) begin
            hz.stall_F = 1'b1;
            hz.stall_D = 1'b1;
            hz.stall_E = 1'b1;
          end else if (lu_hit) begin
            hz.stall_F = 1'b1;
            hz.stall_D = 1'b1;
            hz.flush_E = 1'b1;
          end
        end
        MC_BUSY: begin
          hz.stall_F = 1'b1;
          hz.stall_D = 1'b1;
          hz.stall_E = 1'b1;
        end
        BR_RECOVER: begin
          hz.flush_D = 1'b1;
        end
        default: begin
          hz.flush_D = 1'b0;
        end
      endcase
    end
  end

  // Operand forwarding: memory stage wins over writeback
  always_comb begin
    hz.fwdA_E = 2'b00;
    hz.fwdB_E = 2'b00;
    if (!rst) begin
      if (hz.regw_M && hz.regScr_M == hz.regAE)
        hz.fwdA_E = 2'b10;
      else if (hz.regw_W && hz.regScr_W == hz.regAE)
        hz.fwdA_E = 2'b01;
      if (hz.regw_M && hz.regScr_M == hz.regBE)
        hz.fwdB_E = 2'b10;
      else if (hz.regw_W && hz.regScr_W == hz.regBE)
        hz.fwdB_E = 2'b01;
    end
  end

endmodule
